debug_trig_capture: RTL and testbench

Parametrised N_CH-channel debug capture block for the NAND controller's per-bus debug words. Each cycle it registers all channel words as one sample. A programmable trigger on one selected channel freezes a DEPTH-entry ring buffer, with a pre/post-trigger split chosen at arm time. Host logic (VIO or register interface) arms the block, polls its state and reads out the captured window by relative address. This allows on-chip capture without an ILA core per build.

---
 rtl/debug_cap_pkg.sv | 15 +
 rtl/debug_trig_capture_if.sv | 37 +++
 rtl/debug_cap_ram.sv | 31 +++
 rtl/debug_trig_capture.sv | 139 +++++++++++++
 tb/tb_debug_trig_capture.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_cap_pkg.sv
// Shared definitions for the debug trigger/capture block: capture FSM states
// and the width of the externally visible state code.
package debug_cap_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } cap_state_t;

endpackage

// File: rtl/debug_trig_capture_if.sv
// Host-side bus of the debug capture block: probe input, trigger/arm control
// and the readout/status path.
interface debug_trig_capture_if #(
    parameter int N_CH  = 4,
    parameter int W     = 16,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N_CH);

    logic [N_CH*W-1:0]                   v_probe_in;
    logic                                v_arm;
    logic                                v_abort;
    logic [CW-1:0]                       v_trig_ch;
    logic [W-1:0]                        v_trig_val;
    logic [W-1:0]                        v_trig_mask;
    logic [AW:0]                         v_post_cnt;
    logic [AW-1:0]                       v_rd_addr;
    logic [N_CH*W-1:0]                   v_rd_data;
    logic [debug_cap_pkg::STATE_W-1:0]   v_state;
    logic                                v_done;
    logic [AW-1:0]                       v_trig_pos;
    logic [31:0]                         v_trig_ts;

    modport master (
        output v_probe_in, v_arm, v_abort, v_trig_ch, v_trig_val, v_trig_mask,
               v_post_cnt, v_rd_addr,
        input  v_rd_data, v_state, v_done, v_trig_pos, v_trig_ts
    );

    modport slave (
        input  v_probe_in, v_arm, v_abort, v_trig_ch, v_trig_val, v_trig_mask,
               v_post_cnt, v_rd_addr,
        output v_rd_data, v_state, v_done, v_trig_pos, v_trig_ts
    );

endinterface

// File: rtl/debug_cap_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
// Only the output register is reset; the array itself is left uninitialised.
module debug_cap_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else          r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_trig_capture.sv
// N_CH-channel debug capture: ring buffer frozen by a masked compare on one
// channel, with a pre/post-trigger split chosen when the block is armed.
module debug_trig_capture
    import debug_cap_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 16,
    parameter int DEPTH = 256
) (
    input  logic                 v_clk0,
    input  logic                 v_rst0,
    debug_trig_capture_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N_CH);
    localparam int PW = N_CH * W;
    localparam logic [AW:0]   MAX_POST = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [PW-1:0] r_probe_q;
    cap_state_t    r_state;
    logic [AW-1:0] r_wptr, r_fill, r_rem, r_pre_len, r_post_l, r_trig_pos, r_raddr;
    logic [31:0]   r_ts, r_trig_ts;
    logic          r_done;
    logic [CW-1:0] r_ch;
    logic [W-1:0]  r_val, r_mask;

    logic [W-1:0]  w_sel;
    logic          w_match, w_we, w_arm_ok;
    logic [AW-1:0] w_post_sat, w_pre_len;

    // Input stage: probe words are sampled every cycle regardless of state.
    always_ff @(posedge v_clk0) begin
        r_probe_q <= bus.v_probe_in;
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_ch == CW'(k)) w_sel = r_probe_q[k*W +: W];
        end
    end

    assign w_match    = ((w_sel ^ r_val) & r_mask) == '0;
    assign w_we       = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign w_arm_ok   = bus.v_arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_post_sat = (bus.v_post_cnt > MAX_POST) ? LAST_IDX : bus.v_post_cnt[AW-1:0];
    assign w_pre_len  = LAST_IDX - w_post_sat;

    always_ff @(posedge v_clk0 or negedge v_rst0) begin
        if (!v_rst0) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_fill     <= '0;
            r_rem      <= '0;
            r_ts       <= '0;
            r_trig_ts  <= '0;
            r_trig_pos <= '0;
            r_done     <= 1'b0;
            r_pre_len  <= '0;
            r_post_l   <= '0;
            r_ch       <= '0;
            r_val      <= '0;
            r_mask     <= '0;
        end else if (bus.v_abort) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else if (w_arm_ok) begin
            r_ch      <= bus.v_trig_ch;
            r_val     <= bus.v_trig_val;
            r_mask    <= bus.v_trig_mask;
            r_post_l  <= w_post_sat;
            r_pre_len <= w_pre_len;
            r_wptr    <= '0;
            r_fill    <= '0;
            r_ts      <= '0;
            r_done    <= 1'b0;
            r_state   <= (w_pre_len == '0) ? ST_WAIT : ST_PRE;
        end else begin
            case (r_state)
                ST_PRE: begin
                    r_wptr <= r_wptr + AW'(1);
                    r_fill <= r_fill + AW'(1);
                    r_ts   <= r_ts + 32'd1;
                    if (r_fill == r_pre_len - AW'(1)) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wptr <= r_wptr + AW'(1);
                    r_ts   <= r_ts + 32'd1;
                    if (w_match) begin
                        r_trig_ts  <= r_ts;
                        r_trig_pos <= r_pre_len;
                        r_rem      <= r_post_l;
                        if (r_post_l == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    r_wptr <= r_wptr + AW'(1);
                    r_ts   <= r_ts + 32'd1;
                    r_rem  <= r_rem - AW'(1);
                    // The cycle writing the final post sample also freezes the buffer.
                    if (r_rem == AW'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Readout address stage: once frozen, wptr points at the oldest sample.
    always_ff @(posedge v_clk0 or negedge v_rst0) begin
        if (!v_rst0) r_raddr <= '0;
        else         r_raddr <= r_wptr + bus.v_rd_addr;
    end

    debug_cap_ram #(.DEPTH(DEPTH), .DW(PW), .AW(AW)) u_ram (
        .i_clk   (v_clk0),
        .i_rst_n (v_rst0),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (r_probe_q),
        .i_raddr (r_raddr),
        .o_rdata (bus.v_rd_data)
    );

    assign bus.v_state    = r_state;
    assign bus.v_done     = r_done;
    assign bus.v_trig_pos = r_trig_pos;
    assign bus.v_trig_ts  = r_trig_ts;

endmodule

// File: tb/tb_debug_trig_capture.sv
// Randomised bench for debug_trig_capture with a sample-history reference model.
module tb_debug_trig_capture;

    localparam int N_CH  = 4;
    localparam int W     = 16;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(N_CH);
    localparam int PW    = N_CH * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_trig_capture_if #(.N_CH(N_CH), .W(W), .DEPTH(DEPTH)) bus ();

    debug_trig_capture #(.N_CH(N_CH), .W(W), .DEPTH(DEPTH)) dut (
        .v_clk0 (clk),
        .v_rst0 (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Every value presented on v_probe_in before each recorded clock edge.
    logic [PW-1:0] hist[$];
    logic [PW-1:0] rb[DEPTH];
    int a_idx = 0;
    int m_ch, m_post;
    logic [W-1:0] m_val, m_mask;
    int ramp_base = 0;

    function automatic logic [W-1:0] rand_ch1();
        logic [W-1:0] v;
        v = W'($urandom);
        if (v == 16'h0300) v = 16'h0301;
        return v;
    endfunction

    // md 0: ch1 ramp from ramp_base; md 1: 0x0300 only at k=10 and k=205; md 2: random.
    function automatic logic [PW-1:0] gen_probe(input int md, input int k);
        logic [PW-1:0] p;
        p = {$urandom, $urandom};
        case (md)
            0:       p[W +: W] = W'(ramp_base + k);
            1:       p[W +: W] = (k == 10 || k == 205) ? 16'h0300 : rand_ch1();
            default: p[W +: W] = rand_ch1();
        endcase
        return p;
    endfunction

    function automatic bit mmatch(input logic [PW-1:0] p);
        logic [W-1:0] f;
        f = p[m_ch*W +: W];
        return ((f ^ m_val) & m_mask) == '0;
    endfunction

    task automatic tick(input logic [PW-1:0] p);
        bus.v_probe_in = p;
        hist.push_back(p);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_mode(input int md);
        tick(gen_probe(md, hist.size() - a_idx));
    endtask

    task automatic do_arm(input int ch, input logic [W-1:0] val, input logic [W-1:0] mask,
                          input int post, input int md);
        bus.v_trig_ch   = CW'(ch);
        bus.v_trig_val  = val;
        bus.v_trig_mask = mask;
        bus.v_post_cnt  = (AW+1)'(post);
        bus.v_arm       = 1'b1;
        m_ch = ch; m_val = val; m_mask = mask; m_post = post;
        a_idx = hist.size();
        tick(gen_probe(md, 0));
        bus.v_arm = 1'b0;
    endtask

    // Runs until v_done; optionally pulses a bogus arm at tick arm_at.
    task automatic run_to_done(input int md, input int arm_at, output int di);
        int n;
        n = 0;
        while (!bus.v_done && n < 4000) begin
            if (n == arm_at) begin
                bus.v_trig_ch = '0; bus.v_trig_mask = '0; bus.v_post_cnt = '0;
                bus.v_arm = 1'b1;
            end
            tick_mode(md);
            bus.v_arm = 1'b0;
            n++;
        end
        di = bus.v_done ? hist.size() - 1 : -1;
    endtask

    task automatic check_capture(input string nm, input int di);
        int post_s, pre, t, exp_di, errs, fbi;
        logic [PW-1:0] fb_got, fb_exp, exp_s;
        post_s = (m_post > DEPTH-1) ? DEPTH-1 : m_post;
        pre    = DEPTH - 1 - post_s;
        t      = -1;
        for (int k = pre; a_idx + k < hist.size(); k++) begin
            if (mmatch(hist[a_idx + k])) begin t = k; break; end
        end
        total++;
        if (t < 0 || di < 0) begin
            bad++;
            $display("FAIL %s capture: done_idx=%0d model_trigger=%0d", nm, di, t);
            return;
        end
        exp_di = a_idx + 1 + t + post_s;
        total++;
        if (di !== exp_di) begin
            bad++; $display("FAIL %s done_time: got %0d want %0d", nm, di, exp_di);
        end
        total++;
        if (bus.v_trig_ts !== 32'(t)) begin
            bad++; $display("FAIL %s trig_ts: got %0d want %0d", nm, bus.v_trig_ts, t);
        end
        total++;
        if (bus.v_trig_pos !== AW'(pre)) begin
            bad++; $display("FAIL %s trig_pos: got %0d want %0d", nm, bus.v_trig_pos, pre);
        end
        errs = 0; fbi = -1; fb_got = '0; fb_exp = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) bus.v_rd_addr = AW'(i);
            tick({$urandom, $urandom});
            if (i >= 1) begin
                rb[i-1] = bus.v_rd_data;
                exp_s   = hist[a_idx + t - pre + i - 1];
                if (bus.v_rd_data !== exp_s) begin
                    errs++;
                    if (fbi < 0) begin fbi = i - 1; fb_got = bus.v_rd_data; fb_exp = exp_s; end
                end
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s window: %0d bad entries, first addr %0d got %h want %h",
                     nm, errs, fbi, fb_got, fb_exp);
        end
    endtask

    task automatic check_idle(input string nm);
        total++;
        if (bus.v_state !== 3'd0) begin
            bad++; $display("FAIL %s state: got %0d want 0", nm, bus.v_state);
        end
        total++;
        if (bus.v_done !== 1'b0) begin
            bad++; $display("FAIL %s done: got %0d want 0", nm, bus.v_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        total++;
        if (bus.v_rd_data !== '0 || bus.v_trig_pos !== '0 || bus.v_trig_ts !== '0) begin
            bad++;
            $display("FAIL reset outputs: rd=%h pos=%0d ts=%0d want 0", bus.v_rd_data,
                     bus.v_trig_pos, bus.v_trig_ts);
        end
        rst_n = 1'b1;
        tick({$urandom, $urandom});
        check_idle("reset_release");
    endtask

    task automatic test_ramp();
        int di;
        ramp_base = 16'h0300 - 200;
        do_arm(1, 16'h0300, 16'hFFFF, 100, 0);
        run_to_done(0, -1, di);
        check_capture("ramp", di);
        total++;
        if (di - (a_idx + 1 + 200) !== 100) begin
            bad++; $display("FAIL ramp post_len: got %0d want 100", di - (a_idx + 201));
        end
        total++;
        if (rb[155][W +: W] !== 16'h0300 || rb[0][W +: W] !== 16'h0265 ||
            rb[255][W +: W] !== 16'h0364) begin
            bad++;
            $display("FAIL ramp ch1: [155]=%h [0]=%h [255]=%h want 0300 0265 0364",
                     rb[155][W +: W], rb[0][W +: W], rb[255][W +: W]);
        end
    endtask

    task automatic test_reset_mid_post();
        ramp_base = 16'h0300 - 160;
        bus.v_rd_addr = 8'd7;
        do_arm(1, 16'h0300, 16'hFFFF, 100, 0);
        repeat (170) tick_mode(0);
        total++;
        if (bus.v_state !== 3'd3 || bus.v_trig_ts !== 32'd160) begin
            bad++;
            $display("FAIL midpost precondition: state=%0d ts=%0d want 3 160",
                     bus.v_state, bus.v_trig_ts);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midpost_reset");
        total++;
        if (bus.v_rd_data !== '0 || bus.v_trig_pos !== '0 || bus.v_trig_ts !== '0) begin
            bad++;
            $display("FAIL midpost_reset outputs: rd=%h pos=%0d ts=%0d want 0",
                     bus.v_rd_data, bus.v_trig_pos, bus.v_trig_ts);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick({$urandom, $urandom});
        check_idle("midpost_release");
    endtask

    task automatic test_mask0();
        int di;
        do_arm(2, 16'h1234, 16'h0000, 0, 2);
        run_to_done(2, -1, di);
        check_capture("mask0", di);
        total++;
        if (bus.v_trig_ts !== 32'd255 || bus.v_trig_pos !== 8'd255) begin
            bad++;
            $display("FAIL mask0 trig: ts=%0d pos=%0d want 255 255",
                     bus.v_trig_ts, bus.v_trig_pos);
        end
    endtask

    task automatic test_pre_ignored();
        int di;
        do_arm(1, 16'h0300, 16'hFFFF, 100, 1);
        run_to_done(1, -1, di);
        check_capture("pre_ignored", di);
        total++;
        if (bus.v_trig_ts !== 32'd205) begin
            bad++; $display("FAIL pre_ignored trig_ts: got %0d want 205", bus.v_trig_ts);
        end
    endtask

    task automatic test_abort();
        int di;
        do_arm(1, 16'h0300, 16'hFFFF, 10, 2);
        repeat (250) tick_mode(2);
        total++;
        if (bus.v_state !== 3'd2) begin
            bad++; $display("FAIL abort precondition: state=%0d want 2", bus.v_state);
        end
        bus.v_abort = 1'b1;
        tick_mode(2);
        bus.v_abort = 1'b0;
        check_idle("abort_wait");
        do_arm(1, 16'h0300, 16'hFFFF, 100, 1);
        run_to_done(1, -1, di);
        check_capture("rearm", di);
        total++;
        if (bus.v_done !== 1'b1) begin
            bad++; $display("FAIL rearm done: got %0d want 1", bus.v_done);
        end
        bus.v_abort = 1'b1;
        do_arm(1, 16'h0300, 16'h0000, 0, 2);
        bus.v_abort = 1'b0;
        check_idle("arm_abort");
        tick_mode(2);
        check_idle("arm_abort_hold");
    endtask

    task automatic test_saturate();
        int di;
        ramp_base = 16'h0300 - 5;
        do_arm(1, 16'h0300, 16'hFFFF, 300, 0);
        total++;
        if (bus.v_state !== 3'd2) begin
            bad++; $display("FAIL sat state_after_arm: got %0d want 2", bus.v_state);
        end
        run_to_done(0, 50, di);
        check_capture("saturate", di);
        total++;
        if (bus.v_trig_pos !== 8'd0) begin
            bad++; $display("FAIL sat trig_pos: got %0d want 0", bus.v_trig_pos);
        end
    endtask

    initial begin
        bus.v_probe_in  = '0;
        bus.v_arm       = 1'b0;
        bus.v_abort     = 1'b0;
        bus.v_trig_ch   = '0;
        bus.v_trig_val  = '0;
        bus.v_trig_mask = '0;
        bus.v_post_cnt  = '0;
        bus.v_rd_addr   = '0;
        test_reset();
        test_ramp();
        test_reset_mid_post();
        test_mask0();
        test_pre_ignored();
        test_abort();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
